// File: rtl/sqr_if.sv
// Operand/result bundle for the sequential squarer: start/busy handshake
// plus operand in and squared result out.
interface sqr_if #(parameter int W = 5);
  logic [W-1:0]   a_bi;
  logic           start_i;
  logic           busy_o;
  logic [2*W-1:0] y_bo;

  modport master (output a_bi, start_i, input busy_o, y_bo);
  modport slave  (input a_bi, start_i, output busy_o, y_bo);
endinterface

// File: rtl/sqr.sv
// Sequential shift-and-add squarer: y = a*a, one multiplier bit per two
// cycles (CALC latches the addend, COLLECT accumulates and shifts).
module sqr #(
  parameter int W = 5
) (
  input  logic  clk_i,
  input  logic  rst_i,
  sqr_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, WORK_CALC, WORK_COLLECT} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] addend_q, addend_d;
  logic [CW-1:0]  ctr_q, ctr_d;
  logic [2*W-1:0] y_q, y_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      addend_q <= '0;
      ctr_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      addend_q <= addend_d;
      ctr_q    <= ctr_d;
      y_q      <= y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    addend_d = addend_q;
    ctr_d    = ctr_q;
    y_d      = y_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mcand_d  = {{W{1'b0}}, bus.a_bi};
          mplier_d = bus.a_bi;
          acc_d    = '0;
          ctr_d    = CW'(W);
          state_d  = WORK_CALC;
        end
      end
      WORK_CALC: begin
        // ctr==0 still costs one CALC cycle so latency is fixed at 2W+1
        if (ctr_q == '0) begin
          y_d     = acc_q;
          state_d = IDLE;
        end else begin
          addend_d = mplier_q[0] ? mcand_q : '0;
          state_d  = WORK_COLLECT;
        end
      end
      WORK_COLLECT: begin
        acc_d    = acc_q + addend_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        ctr_d    = ctr_q - CW'(1);
        state_d  = WORK_CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.y_bo   = y_q;
endmodule

// File: tb/tb_sqr.sv
// Directed bench for sqr: scoreboard of expected squares, busy-length
// checks, held/pulsed start, sync/async reset, exhaustive round-trip.
module tb_sqr;
  localparam int W = 5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int a;
    int y;
  } exp_t;
  exp_t sb_q[$];

  sqr_if #(.W(W)) sif ();

  sqr #(.W(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start and queue the expected square.
  task automatic launch(input int a);
    sb_q.push_back('{a: a, y: a * a});
    sif.a_bi    = W'(a);
    sif.start_i = 1'b1;
    tick();
    sif.start_i = 1'b0;
  endtask

  // Entered one edge after an accepted start; counts busy cycles, then
  // pops the scoreboard and checks the result and its root.
  task automatic finish_op(input string tag, input bit pulse, input bit root);
    int   cnt = 1;
    exp_t e;
    while (sif.busy_o && cnt < 50) begin
      if (pulse) sif.start_i = ~sif.start_i;
      tick();
      if (sif.busy_o) cnt++;
    end
    if (pulse) sif.start_i = 1'b0;
    chk({tag, "_busy_len"}, cnt, 2 * W + 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_y"}, int'(sif.y_bo), e.y);
      if (root) chk({tag, "_root"}, isqrt(int'(sif.y_bo)), e.a);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sif.a_bi    = '0;
    sif.start_i = 1'b0;

    // Reset held 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_y", int'(sif.y_bo), 0);
      chk("rst_busy", int'(sif.busy_o), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(sif.busy_o), 0);

    // Max and zero operands
    launch(31);
    finish_op("a31", 1'b0, 1'b0);
    chk("a31_after_busy", int'(sif.busy_o), 0);
    launch(0);
    finish_op("a0", 1'b0, 1'b0);

    // Held start; operand change mid-run ignored; back-to-back at 2W+2
    sb_q.push_back('{a: 25, y: 625});
    sif.a_bi    = 5'd25;
    sif.start_i = 1'b1;
    tick();
    sif.a_bi = 5'd7;
    finish_op("held25", 1'b0, 1'b0);
    chk("held_gap_busy", int'(sif.busy_o), 0);
    sb_q.push_back('{a: 7, y: 49});
    tick();
    chk("held_restart_busy", int'(sif.busy_o), 1);
    sif.start_i = 1'b0;
    finish_op("held7", 1'b0, 1'b0);

    // Start pulsed during busy: one result only
    launch(20);
    finish_op("pulse20", 1'b1, 1'b0);
    tick();
    tick();
    chk("pulse_no_extra", int'(sif.busy_o), 0);
    chk("pulse_y_hold", int'(sif.y_bo), 400);

    // Reset mid-operation aborts immediately
    sif.a_bi    = 5'd30;
    sif.start_i = 1'b1;
    tick();
    sif.start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_y", int'(sif.y_bo), 0);
    chk("midrst_busy", int'(sif.busy_o), 0);
    tick();
    rst_n = 1'b1;
    launch(3);
    finish_op("after_rst3", 1'b0, 1'b0);

    // Reset pulsed between edges while idle with a nonzero result
    #2;
    rst_n = 1'b0;
    #2;
    chk("async_rst_y", int'(sif.y_bo), 0);
    chk("async_rst_busy", int'(sif.busy_o), 0);
    rst_n = 1'b1;
    tick();
    chk("async_rst_idle", int'(sif.busy_o), 0);

    // Exhaustive round-trip
    for (int a = 0; a < 32; a++) begin
      launch(a);
      finish_op("exh", 1'b0, 1'b1);
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
